// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : iter_shift_unit
// Function : multi-cycle SLL/SRL/SRA/ROR shifter, at most STEP bits per clock
// Revision : 1.0
// ============================================================================
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0]       c_OP_SLL = 2'b00;
  localparam logic [1:0]       c_OP_SRL = 2'b01;
  localparam logic [1:0]       c_OP_SRA = 2'b10;
  localparam logic [SHAMT_W:0] c_STEP   = STEP[SHAMT_W:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_sreg;
  logic [WIDTH-1:0]     r_result;
  logic [1:0]           r_op;
  logic [SHAMT_W-1:0]   r_rem;

  logic [SHAMT_W:0]     w_rem_ext;
  logic [SHAMT_W:0]     w_amt;
  logic [SHAMT_W-1:0]   w_rem_next;
  logic [WIDTH-1:0]     w_shifted;
  logic [2*WIDTH-1:0]   w_sll_ext;
  logic [2*WIDTH-1:0]   w_srl_ext;
  logic [2*WIDTH-1:0]   w_sra_ext;
  logic [2*WIDTH-1:0]   w_ror_ext;
  logic [STEP:0][WIDTH-1:0] w_cand;

  assign w_rem_ext  = {1'b0, r_rem};
  assign w_amt      = (w_rem_ext < c_STEP) ? w_rem_ext : c_STEP;
  // w_amt never exceeds r_rem, which is below WIDTH, so the truncation is lossless
  assign w_rem_next = r_rem - w_amt[SHAMT_W-1:0];

  // Each shift flavour is a fixed-offset window into a double-width vector
  assign w_sll_ext = {r_sreg, {WIDTH{1'b0}}};
  assign w_srl_ext = {{WIDTH{1'b0}}, r_sreg};
  assign w_sra_ext = {{WIDTH{r_sreg[WIDTH-1]}}, r_sreg};
  assign w_ror_ext = {r_sreg, r_sreg};

  generate
    for (genvar k = 0; k <= STEP; k++) begin : g_step
      assign w_cand[k] = (r_op == c_OP_SLL) ? w_sll_ext[WIDTH-k +: WIDTH] :
                         (r_op == c_OP_SRL) ? w_srl_ext[k +: WIDTH] :
                         (r_op == c_OP_SRA) ? w_sra_ext[k +: WIDTH] :
                                              w_ror_ext[k +: WIDTH];
    end
  endgenerate

  always_comb begin
    w_shifted = w_cand[0];
    for (int k = 1; k <= STEP; k++) begin
      if (w_amt == (SHAMT_W+1)'(k)) w_shifted = w_cand[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = (shamt == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_rem_next == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // result only moves on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg   <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sreg <= data_in;
            r_op   <= op;
            r_rem  <= shamt;
            if (shamt == '0) r_result <= data_in;
          end
        end
        S_SHIFT: begin
          r_sreg <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) r_result <= w_shifted;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire
